// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: opcodes, FSM states and default sizing shared by the memory access unit
package mem_access_unit_pkg;
  localparam int MEM_WORDS_D = 2048;
  localparam logic [31:0] SP_RESET_D = 32'd2047;
  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_STORE = 3'd2, OP_PUSH = 3'd3,
                         OP_POP = 3'd4, OP_PUSH32 = 3'd5, OP_POP32 = 3'd6, OP_RSVD = 3'd7;
  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;
  function automatic logic is_rd(input logic [2:0] op);
    return op inside {OP_LOAD, OP_POP, OP_POP32};
  endfunction
  function automatic logic is_wr(input logic [2:0] op);
    return op inside {OP_STORE, OP_PUSH, OP_PUSH32};
  endfunction
  function automatic logic is_dbl(input logic [2:0] op);
    return op inside {OP_PUSH32, OP_POP32};
  endfunction
  function automatic logic is_mem(input logic [2:0] op);
    return is_rd(op) || is_wr(op);
  endfunction
endpackage

// File: rtl/mam_sp_unit.sv
// mam_sp_unit: stack pointer register, SP-relative addresses, next-SP and access range check
module mam_sp_unit import mem_access_unit_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int MEM_WORDS = MEM_WORDS_D,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_D)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        chk_op,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic              upd,
  input  logic [2:0]        upd_op,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_m1,
  output logic [ADDR_W-1:0] sp_p1,
  output logic [ADDR_W-1:0] sp_p2,
  output logic              in_range
);
  logic [ADDR_W-1:0] sp_n;
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(MEM_WORDS);
  endfunction
  assign sp_m1 = sp - ADDR_W'(1);
  assign sp_p1 = sp + ADDR_W'(1);
  assign sp_p2 = sp + ADDR_W'(2);
  // wrapped SP-relative addresses land far above MEM_WORDS, so the same check catches them
  always_comb begin
    in_range = 1'b1;
    case (chk_op)
      OP_LOAD, OP_STORE: in_range = ok(chk_addr);
      OP_PUSH:           in_range = ok(sp);
      OP_POP:            in_range = ok(sp_p1);
      OP_PUSH32:         in_range = ok(sp) && ok(sp_m1);
      OP_POP32:          in_range = ok(sp_p1) && ok(sp_p2);
      default:           in_range = 1'b1;
    endcase
  end
  always_comb begin
    sp_n = sp;
    case (upd_op)
      OP_PUSH:   sp_n = sp_m1;
      OP_POP:    sp_n = sp_p1;
      OP_PUSH32: sp_n = sp - ADDR_W'(2);
      OP_POP32:  sp_n = sp_p2;
      default:   sp_n = sp;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sp <= SP_RESET;
    else if (upd) sp <= sp_n;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage initiator sequencing one or two 16-bit data memory accesses per request
module mem_access_unit import mem_access_unit_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int MEM_WORDS = MEM_WORDS_D,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_D)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [2:0]          ReqOp,
  input  logic [ADDR_W-1:0]   ReqAddr,
  input  logic [2*DATA_W-1:0] ReqData,
  output logic                RespValid,
  output logic [2*DATA_W-1:0] RespData,
  output logic                RespErr,
  output logic [ADDR_W-1:0]   SpOut,
  output logic [DATA_W-1:0]   DataIn,
  output logic [ADDR_W-1:0]   Address,
  output logic                MemoryRead,
  output logic                MemoryWrite,
  input  logic [DATA_W-1:0]   DataOut
);
  state_t state, state_n;
  logic [2:0] op;
  logic [ADDR_W-1:0] addr2, first_addr, addr_n, sp_m1, sp_p1, sp_p2;
  logic [DATA_W-1:0] data2, lo, first_data, din_n;
  logic [2*DATA_W-1:0] rdata_n;
  logic accept, go, in_range, upd, rd_n, wr_n, err_n;
  assign ReqReady = state == IDLE;
  assign RespValid = state == RESP;
  assign accept = ReqValid && ReqReady;
  assign go = accept && is_mem(ReqOp) && in_range;
  assign upd = (state == ACC_LO && !is_dbl(op)) || state == ACC_HI;
  assign first_addr = ReqOp inside {OP_LOAD, OP_STORE} ? ReqAddr :
                      ReqOp inside {OP_PUSH, OP_PUSH32} ? SpOut : sp_p1;
  assign first_data = ReqOp == OP_PUSH32 ? ReqData[2*DATA_W-1:DATA_W] : ReqData[DATA_W-1:0];
  mam_sp_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .SP_RESET(SP_RESET)) u_sp (
    .clk(clk), .rst_n(rst_n), .chk_op(ReqOp), .chk_addr(ReqAddr), .upd(upd), .upd_op(op),
    .sp(SpOut), .sp_m1(sp_m1), .sp_p1(sp_p1), .sp_p2(sp_p2), .in_range(in_range)
  );
  // strobes and response fields are computed here and registered, so they only change on edges
  always_comb begin
    state_n = state;
    addr_n = Address;
    din_n = DataIn;
    rd_n = 1'b0;
    wr_n = 1'b0;
    rdata_n = RespData;
    err_n = RespErr;
    case (state)
      IDLE: if (accept) begin
        state_n = go ? ACC_LO : RESP;
        addr_n = go ? first_addr : Address;
        din_n = go && is_wr(ReqOp) ? first_data : DataIn;
        rd_n = go && is_rd(ReqOp);
        wr_n = go && is_wr(ReqOp);
        rdata_n = go ? RespData : '0;
        err_n = go ? RespErr : ReqOp != OP_NOP;
      end
      ACC_LO: begin
        state_n = is_dbl(op) ? ACC_HI : RESP;
        addr_n = is_dbl(op) ? addr2 : Address;
        din_n = is_dbl(op) && MemoryWrite ? data2 : DataIn;
        rd_n = is_dbl(op) && MemoryRead;
        wr_n = is_dbl(op) && MemoryWrite;
        rdata_n = is_dbl(op) ? RespData : {{DATA_W{1'b0}}, MemoryRead ? DataOut : {DATA_W{1'b0}}};
        err_n = is_dbl(op) ? RespErr : 1'b0;
      end
      ACC_HI: begin
        state_n = RESP;
        rdata_n = MemoryRead ? {DataOut, lo} : '0;
        err_n = 1'b0;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      Address <= '0;
      DataIn <= '0;
      MemoryRead <= 1'b0;
      MemoryWrite <= 1'b0;
      RespData <= '0;
      RespErr <= 1'b0;
      op <= OP_NOP;
      addr2 <= '0;
      data2 <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      Address <= addr_n;
      DataIn <= din_n;
      MemoryRead <= rd_n;
      MemoryWrite <= wr_n;
      RespData <= rdata_n;
      RespErr <= err_n;
      if (state == ACC_LO) lo <= DataOut;
      if (accept) begin
        op <= ReqOp;
        addr2 <= ReqOp == OP_PUSH32 ? sp_m1 : sp_p2;
        data2 <= ReqData[DATA_W-1:0];
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a word-level memory/stack model
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  typedef struct packed {logic [1:0] rel; logic wr; logic [31:0] a; logic [15:0] d;} acc_t;
  logic clk = 0, rst_n = 0, ReqValid = 0, ReqReady, RespValid, RespErr, MemoryRead, MemoryWrite;
  logic [2:0] ReqOp = 0;
  logic [31:0] ReqAddr = 0, ReqData = 0, RespData, SpOut, Address;
  logic [15:0] DataIn, DataOut;
  logic [15:0] mem [0:2047];
  logic [15:0] ref_mem [0:2047];
  logic [31:0] ref_sp = 32'd2047;
  logic mem_init = 1, both_hi = 0;
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
  acc_t seen[$], exp_q[$];
  logic [31:0] got_d, exp_d;
  logic got_e, exp_e, got_rdy;
  int got_lat, exp_lat;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RespValid(RespValid), .RespData(RespData),
    .RespErr(RespErr), .SpOut(SpOut), .DataIn(DataIn), .Address(Address),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .DataOut(DataOut)
  );

  assign DataOut = mem[Address[10:0]];
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 2048; i++) mem[i] <= 16'(i * 37 + 5);
    else if (MemoryWrite && Address < 32'd2048) mem[Address[10:0]] <= DataIn;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (MemoryRead && MemoryWrite) both_hi <= 1'b1;
    if (MemoryRead || MemoryWrite)
      seen.push_back(acc_t'{rel: 2'(cyc - acc_cyc), wr: MemoryWrite, a: Address, d: MemoryWrite ? DataIn : 16'h0});
  end

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] t[$];
    logic bad;
    logic [15:0] v;
    exp_q.delete();
    exp_d = 0;
    exp_e = 0;
    exp_lat = 1;
    case (op)
      OP_LOAD, OP_STORE: t = {a};
      OP_PUSH: t = {ref_sp};
      OP_POP: t = {ref_sp + 32'd1};
      OP_PUSH32: t = {ref_sp, ref_sp - 32'd1};
      OP_POP32: t = {ref_sp + 32'd1, ref_sp + 32'd2};
      default: t = {};
    endcase
    bad = op == OP_RSVD;
    foreach (t[i]) if (t[i] >= 32'd2048) bad = 1;
    if (bad) begin
      exp_e = 1;
      return;
    end
    if (op == OP_NOP) return;
    exp_lat = t.size() + 1;
    foreach (t[i]) begin
      if (op inside {OP_STORE, OP_PUSH, OP_PUSH32}) begin
        v = (op == OP_PUSH32 && i == 0) ? d[31:16] : d[15:0];
        ref_mem[t[i][10:0]] = v;
        exp_q.push_back(acc_t'{rel: 2'(i + 1), wr: 1'b1, a: t[i], d: v});
      end else begin
        v = ref_mem[t[i][10:0]];
        exp_d = exp_d | (32'(v) << (16 * i));
        exp_q.push_back(acc_t'{rel: 2'(i + 1), wr: 1'b0, a: t[i], d: 16'h0});
      end
    end
    case (op)
      OP_PUSH: ref_sp = ref_sp - 32'd1;
      OP_POP: ref_sp = ref_sp + 32'd1;
      OP_PUSH32: ref_sp = ref_sp - 32'd2;
      OP_POP32: ref_sp = ref_sp + 32'd2;
      default: ;
    endcase
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int k = 0;
    model(op, a, d);
    seen.delete();
    got_rdy = 0;
    got_lat = 0;
    got_d = 0;
    got_e = 0;
    while (!ReqReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ReqReady) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout op=%0d ReqReady=%b required 1", op, ReqReady);
    end
    ReqValid = 1;
    ReqOp = op;
    ReqAddr = a;
    ReqData = d;
    acc_cyc = cyc;
    for (int i = 1; i <= 8 && got_lat == 0; i++) begin
      @(negedge clk);
      ReqValid = 0;
      if (RespValid) begin
        got_lat = i;
        got_d = RespData;
        got_e = RespErr;
      end else if (ReqReady) got_rdy = 1;
    end
    if (got_lat == 0) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout op=%0d no RespValid within 8 cycles", op);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    mem_init = 0;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({ReqReady, RespValid, RespData, RespErr, SpOut, DataIn, Address, MemoryRead, MemoryWrite} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 32'd2047, 16'h0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state rdy=%b rv=%b rd=%h re=%b sp=%0d din=%h addr=%h mr=%b mw=%b required 1 0 0 0 2047 0 0 0 0",
               ReqReady, RespValid, RespData, RespErr, SpOut, DataIn, Address, MemoryRead, MemoryWrite);
    end
  endtask

  task automatic test_store_load;
    run(OP_STORE, 32'd5, 32'h0000BEEF);
    checks++;
    if (seen.size() != 1 || seen[0] !== acc_t'{rel: 2'd1, wr: 1'b1, a: 32'd5, d: 16'hBEEF}) begin
      failures++;
      $display("FAIL store_strobe count=%0d first=%h required 1 write of BEEF at 5 in N+1", seen.size(), seen[0]);
    end
    checks++;
    if (got_lat !== 2 || got_e !== 1'b0) begin
      failures++;
      $display("FAIL store_resp lat=%0d err=%b required lat=2 err=0", got_lat, got_e);
    end
    run(OP_LOAD, 32'd5, 32'h0);
    checks++;
    if (got_d !== 32'h0000BEEF || got_e !== 1'b0 || got_lat !== 2) begin
      failures++;
      $display("FAIL load_resp data=%h err=%b lat=%0d required 0000beef 0 2", got_d, got_e, got_lat);
    end
    checks++;
    if (seen.size() != 1 || seen[0] !== acc_t'{rel: 2'd1, wr: 1'b0, a: 32'd5, d: 16'h0}) begin
      failures++;
      $display("FAIL load_strobe count=%0d first=%h required 1 read at 5 in N+1", seen.size(), seen[0]);
    end
    @(negedge clk);
    checks++;
    if (ReqReady !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_resp ReqReady=%b required 1", ReqReady);
    end
  endtask

  task automatic test_push_pop;
    run(OP_PUSH, 32'h0, 32'h00001234);
    checks++;
    if (seen.size() != 1 || seen[0] !== acc_t'{rel: 2'd1, wr: 1'b1, a: 32'd2047, d: 16'h1234} || SpOut !== 32'd2046) begin
      failures++;
      $display("FAIL push count=%0d first=%h sp=%0d required write 1234@2047 sp=2046", seen.size(), seen[0], SpOut);
    end
    run(OP_POP, 32'h0, 32'h0);
    checks++;
    if (got_d !== 32'h00001234 || got_e !== 1'b0 || SpOut !== 32'd2047 || seen.size() != 1 || seen[0].a !== 32'd2047) begin
      failures++;
      $display("FAIL pop data=%h err=%b sp=%0d count=%0d required 00001234 0 2047 1", got_d, got_e, SpOut, seen.size());
    end
  endtask

  task automatic test_push32_pop32;
    run(OP_PUSH32, 32'h0, 32'hAAAA5555);
    checks++;
    if (seen.size() != 2 || seen[0] !== acc_t'{rel: 2'd1, wr: 1'b1, a: 32'd2047, d: 16'hAAAA} ||
        seen[1] !== acc_t'{rel: 2'd2, wr: 1'b1, a: 32'd2046, d: 16'h5555}) begin
      failures++;
      $display("FAIL push32_strobes count=%0d s0=%h s1=%h required AAAA@2047 then 5555@2046", seen.size(), seen[0], seen[1]);
    end
    checks++;
    if (SpOut !== 32'd2045 || got_lat !== 3) begin
      failures++;
      $display("FAIL push32_sp sp=%0d lat=%0d required 2045 3", SpOut, got_lat);
    end
    run(OP_POP32, 32'h0, 32'h0);
    checks++;
    if (got_d !== 32'hAAAA5555 || got_e !== 1'b0 || SpOut !== 32'd2047 || got_lat !== 3) begin
      failures++;
      $display("FAIL pop32 data=%h err=%b sp=%0d lat=%0d required aaaa5555 0 2047 3", got_d, got_e, SpOut, got_lat);
    end
    checks++;
    if (seen.size() != 2 || seen[0].a !== 32'd2046 || seen[1].a !== 32'd2047 || seen[1].rel !== 2'd2 || seen[0].wr || seen[1].wr) begin
      failures++;
      $display("FAIL pop32_strobes count=%0d s0=%h s1=%h required reads 2046 then 2047", seen.size(), seen[0], seen[1]);
    end
  endtask

  task automatic test_pop_empty;
    run(OP_POP, 32'h0, 32'h0);
    checks++;
    if (got_e !== 1'b1 || got_lat !== 1 || seen.size() != 0 || SpOut !== 32'd2047) begin
      failures++;
      $display("FAIL pop_empty err=%b lat=%0d strobes=%0d sp=%0d required 1 1 0 2047", got_e, got_lat, seen.size(), SpOut);
    end
  endtask

  task automatic test_errors;
    logic [2:0] ops [3] = '{OP_LOAD, OP_RSVD, OP_NOP};
    for (int i = 0; i < 3; i++) begin
      run(ops[i], 32'h00000800, 32'h0);
      checks++;
      if (got_e !== (ops[i] != OP_NOP) || got_lat !== 1 || seen.size() != 0 || ReqReady !== 1'b0) begin
        failures++;
        $display("FAIL err_op%0d err=%b lat=%0d strobes=%0d rdy=%b required %b 1 0 0", ops[i], got_e, got_lat, seen.size(), ReqReady, ops[i] != OP_NOP);
      end
      @(negedge clk);
      checks++;
      if (ReqReady !== 1'b1) begin
        failures++;
        $display("FAIL err_ready_op%0d ReqReady=%b required 1", ops[i], ReqReady);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0] op;
    logic [31:0] a;
    int sel;
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a = sel < 6 ? 32'($urandom_range(0, 15)) : sel < 8 ? 32'($urandom_range(2040, 2047)) :
          sel == 8 ? 32'($urandom_range(2048, 2051)) : 32'($urandom);
      run(op, a, 32'($urandom));
      checks++;
      if (got_e !== exp_e || got_lat !== exp_lat || SpOut !== ref_sp || got_rdy !== 1'b0) begin
        failures++;
        $display("FAIL rnd_resp n=%0d op=%0d err=%b lat=%0d sp=%0d rdy=%b required %b %0d %0d 0", n, op, got_e, got_lat, SpOut, got_rdy, exp_e, exp_lat, ref_sp);
      end
      if (!exp_e && op inside {OP_LOAD, OP_POP, OP_POP32}) begin
        checks++;
        if (got_d !== exp_d) begin
          failures++;
          $display("FAIL rnd_data n=%0d op=%0d data=%h required %h", n, op, got_d, exp_d);
        end
      end
      checks++;
      if (seen.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rnd_strobe_count n=%0d op=%0d count=%0d required %0d", n, op, seen.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (seen[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rnd_strobe n=%0d idx=%0d got=%h required %h", n, i, seen[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int k = 0;
    logic rv = 0;
    while (!ReqReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    ReqValid = 1;
    ReqOp = OP_PUSH32;
    ReqData = 32'h12345678;
    @(negedge clk);
    ReqValid = 0;
    @(posedge clk);
    #2;
    checks++;
    if (MemoryWrite !== 1'b1) begin
      failures++;
      $display("FAIL mid_acc_hi MemoryWrite=%b required 1 in second access", MemoryWrite);
    end
    rst_n = 0;
    #1;
    checks++;
    if (MemoryWrite !== 1'b0) begin
      failures++;
      $display("FAIL mid_strobe_drop MemoryWrite=%b required 0", MemoryWrite);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      rv = rv | RespValid;
    end
    checks++;
    if (rv !== 1'b0 || SpOut !== 32'd2047) begin
      failures++;
      $display("FAIL mid_reset resp_seen=%b sp=%0d required 0 2047", rv, SpOut);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 16'(i * 37 + 5);
    test_reset();
    test_store_load();
    test_push_pop();
    test_push32_pop32();
    test_pop_empty();
    test_errors();
    test_random();
    test_reset_mid();
    checks++;
    if (both_hi !== 1'b0) begin
      failures++;
      $display("FAIL strobe_exclusive both_high_seen=%b required 0", both_hi);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage initiator for the 16-bit data memory. It accepts one load/store/stack request at a time from the pipeline and owns the stack pointer. It sequences one or two 16-bit memory accesses per request, so 32-bit values such as return PCs take two accesses. It drives the memory's DataIn/Address/MemoryRead/MemoryWrite inputs, captures DataOut, and returns a single-cycle response to the pipeline.

## Interface
- ADDR_W, 32, address and SP width
- DATA_W, 16, memory word width
- MEM_WORDS, 2048, number of valid word addresses (0 to MEM_WORDS-1)
- SP_RESET, 32'd2047, stack pointer value after reset (top of memory)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ReqValid  in  1  pipeline request present
- ReqReady  out  1  unit can accept a request
- ReqOp  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH32, 6 POP32, 7 reserved
- ReqAddr  in  ADDR_W  word address for LOAD/STORE
- ReqData  in  2*DATA_W  store/push data; only [15:0] is used except by PUSH32
- RespValid  out  1  one-cycle response pulse
- RespData  out  2*DATA_W  load/pop result; upper half is zero for 16-bit ops
- RespErr  out  1  address-range or reserved-op error, valid with RespValid
- SpOut  out  ADDR_W  current stack pointer
- DataIn  out  DATA_W  write data to memory
- Address  out  ADDR_W  memory word address
- MemoryRead  out  1  read enable
- MemoryWrite  out  1  write enable
- DataOut  in  DATA_W  combinational read data from memory

## Operation
- States: IDLE, ACC_LO, ACC_HI, RESP. ReqReady=1 only in IDLE.
- Accept rule: a request is accepted when ReqValid and ReqReady are both high. Op, address and data are latched on acceptance.
- Per-op memory sequence (memory outputs are registered and become active in the access state):
  - LOAD: read ReqAddr.
  - STORE: write ReqData[15:0] to ReqAddr.
  - PUSH: write ReqData[15:0] to SP; then SP = SP-1.
  - POP: read SP+1; then SP = SP+1.
  - PUSH32: ACC_LO writes ReqData[31:16] to SP; ACC_HI writes ReqData[15:0] to SP-1; then SP = SP-2.
  - POP32: ACC_LO reads SP+1 into RespData[15:0]; ACC_HI reads SP+2 into RespData[31:16]; then SP = SP+2.
- State transitions:
  - IDLE goes to ACC_LO on acceptance.
  - ACC_LO goes to ACC_HI for PUSH32/POP32, otherwise to RESP.
  - ACC_HI goes to RESP.
  - RESP goes to IDLE.
- SP is updated on the edge that leaves the last access state.
- Read data is sampled from DataOut at the end of the access cycle.
- Range check at acceptance: every address the op will touch must be below MEM_WORDS. If any is not, no strobe is issued, SP is unchanged, and RESP is entered directly with RespErr=1.
- NOP: no strobe; RESP is entered directly with RespErr=0.
- Reserved op (7): no strobe; RESP is entered directly with RespErr=1.
- SP arithmetic is modulo 2^ADDR_W. An address that wraps is caught by the range check.
- Outside access states, MemoryRead=MemoryWrite=0. Address and DataIn hold their last values.
- Only one of MemoryRead and MemoryWrite is ever high in any cycle.

## Timing
- Reset values: ReqReady=1, RespValid=0, RespData=0, RespErr=0, SpOut=SP_RESET, DataIn=0, Address=0, MemoryRead=0, MemoryWrite=0, state IDLE.
- Latency for a request accepted in cycle N:
  - Single-access op: strobe in N+1, RespValid in N+2, next accept in N+3.
  - Double-access op: strobes in N+1 and N+2, RespValid in N+3.
  - Error or NOP: RespValid in N+1.
- The response has no backpressure. RespValid is high for exactly one cycle; RespData and RespErr hold until the next response.
- For each write, DataIn, Address and MemoryWrite change on the same edge and are stable for the whole cycle.
- Reset asserted mid-operation: strobes drop immediately (asynchronously), no response is issued, and SP returns to SP_RESET.

## Structure
- Shared package contains:
  - opcode constants, NOP through reserved
  - state encoding
  - MEM_WORDS and SP_RESET defaults
- One natural sub-module, mam_sp_unit: holds SP, computes the SP-relative access addresses (SP, SP-1, SP+1, SP+2) and the next SP, and performs the range check.

## Test plan
- Reset, then STORE ReqAddr=5, ReqData=16'hBEEF, then LOAD 5 -> one MemoryWrite cycle at Address=5; LOAD response RespData=32'h0000BEEF, RespErr=0.
- PUSH 16'h1234 then POP -> write at 2047, SpOut=2046; POP reads 2047, RespData=32'h00001234, SpOut=2047.
- PUSH32 32'hAAAA5555 then POP32 -> writes AAAA@2047, 5555@2046, SpOut=2045; POP32 returns 32'hAAAA5555, SpOut=2047.
- POP with SpOut=2047 (SP+1 = 2048) -> no strobe, RespErr=1 one cycle after acceptance, SpOut stays 2047.
- LOAD ReqAddr=32'h00000800 and reserved op 7 -> each gives RespErr=1 with no strobe; ReqReady is low only between acceptance and the response.
- rst_n pulsed low during ACC_HI of a PUSH32 -> MemoryWrite drops immediately, no RespValid, SpOut=2047 after reset.
